s27_scan_seq: RTL and testbench
===============================

Name: s27_scan_seq

Overview:
- Scan/BIST sequencer for the s27 core (3 state flops DFF_0..DFF_2 stitched into one scan chain, primary inputs G0..G3, output G17).
- Per pattern: generates pseudo-random patterns with an LFSR, shifts state into the chain, applies one capture cycle, and compacts G17 plus scan-out into a MISR signature.
- Sits beside the s27 netlist in the timing test harness and owns its scan-enable, scan-in, capture-enable and primary-input pins.

Parameters:
- CHAIN_LEN, 3, number of scan flops in the chain.
- NPAT_W, 8, width of the pattern-count input.
- SIG_W, 16, width of the LFSR and the MISR.
- POLY, 16'hB400, feedback polynomial shared by the LFSR and the MISR.

Ports:
- CK, input, 1, rising-edge clock.
- RN, input, 1, asynchronous active-low reset.
- start, input, 1, begin a run; honoured only in IDLE.
- abort, input, 1, synchronous abort to IDLE.
- npat, input, NPAT_W, number of patterns; sampled on start.
- seed, input, SIG_W, LFSR seed; sampled on start.
- busy, output, 1, high in SHIFT, CAPTURE and FLUSH.
- done, output, 1, one-cycle pulse on run completion.
- signature, output, SIG_W, MISR value; held after done.
- SE, output, 1, scan enable to the core.
- SI, output, 1, scan-in bit.
- CE, output, 1, functional capture enable.
- PI, output, 4, drives G3..G0 (PI[0]=G0).
- SO, input, 1, scan-out from the last flop.
- G17, input, 1, core primary output.

Behaviour:
- Reset (RN=0, asynchronous): state=IDLE; busy, done, SE, SI and CE = 0; PI=0; signature=0; LFSR=1; pattern counter=0.
- All outputs are registered; no combinational path from any input to any output.
- LFSR step (Galois, right shift): lfsr <= (lfsr>>1) ^ (lfsr[0] ? POLY : 0).
- MISR step with input bit b: misr <= {misr[SIG_W-2:0],1'b0} ^ (misr[SIG_W-1] ? POLY : 0) ^ b.
- IDLE:
  - start=1 loads lfsr=seed (seed==0 is replaced by 1), clears misr, pcnt=0, first=1.
  - Next state is SHIFT, or DONE if npat==0.
  - start is ignored in every state except IDLE.
- SHIFT, CHAIN_LEN cycles:
  - SE=1, SI=lfsr[0], LFSR steps each cycle.
  - SO is compacted into the MISR on each cycle unless first=1; the chain content before the first load is unknown, so it is masked.
  - After the last shift cycle, go to CAPTURE.
- CAPTURE, 1 cycle:
  - SE=0, CE=1, PI=lfsr[3:0] (the LFSR does not step).
  - G17 is compacted into the MISR; first is cleared and pcnt increments.
  - Next state is SHIFT if pcnt+1<npat, else FLUSH.
  - PI holds its value until the next CAPTURE.
- FLUSH, CHAIN_LEN cycles: SE=1, SI=0, SO compacted; then go to DONE.
- DONE, 1 cycle: done=1, signature <= misr; then IDLE.
- The signature output updates only in DONE; it holds across IDLE and the next run until the next DONE.
- abort=1 in any non-IDLE state:
  - Next state is IDLE; SE and CE are deasserted next cycle.
  - done is not pulsed and signature keeps its previous value.
  - abort has priority over every other transition.
- Timing: start sampled at edge 0 with npat=1 gives
  - SHIFT at cycles 1-3, CAPTURE at 4, FLUSH at 5-7, DONE at 8;
  - busy high at cycles 1-7.
- General run length: npat*(CHAIN_LEN+1)+CHAIN_LEN+1 cycles from start to the done pulse.
- Shift counter width is clog2(CHAIN_LEN+1); pcnt width is NPAT_W. npat=2^NPAT_W-1 must complete without wrap.
- SE and CE are never high in the same cycle.

Decomposition:
- Package s27_scan_pkg holds:
  - the state enum (IDLE, SHIFT, CAPTURE, FLUSH, DONE);
  - the POLY default and the SIG_W default;
  - a function for one Galois step, used by both the LFSR and the MISR.
- Sub-module s27_sig_reg: a SIG_W-bit register with load, clear, step enable and serial input, selectable LFSR or MISR mode. The sequencer instantiates it twice.

Test Plan:
- Reset mid-SHIFT: pull RN low → all outputs 0 in the same cycle (asynchronous); state IDLE after RN rises; signature=0.
- seed=16'h0001, npat=1, SO held 1, G17 held 0:
  - SI sequence 1,0,0; LFSR values 0x0001→0xB400→0x5A00→0x2D00.
  - PI=4'h0 at CAPTURE; done at cycle 8; signature=16'h0007.
- npat=0 → busy never high; done pulses 1 cycle after start; signature=16'h0000.
- npat=3, seed=0:
  - behaves exactly like seed=1;
  - done at cycle 3*4+4=16;
  - SO ignored during the first SHIFT only: toggling SO there does not change the signature, toggling it later does.
- abort asserted at CAPTURE of pattern 2 of 5 → IDLE next cycle; SE=CE=0; no done pulse; signature unchanged from the prior run.
- start held high through a whole run → it is ignored while busy; a new run starts on the cycle after DONE.
- Every run: SE and CE are never both 1.

Source files
------------

// File: rtl/s27_scan_pkg.sv
`default_nettype none
// ============================================================================
// Module      : s27_scan_pkg
// Description : Shared types, defaults and the Galois step used by the s27
//               scan/BIST sequencer (LFSR pattern source and MISR compactor).
// Revision    : 1.0 - initial release
// ============================================================================
package s27_scan_pkg;

  // Default signature/LFSR width and the shared feedback polynomial.
  localparam int unsigned C_SIG_W = 16;
  localparam logic [C_SIG_W-1:0] C_POLY = 16'hB400;

  // Working width of the step function; register widths must stay below it.
  localparam int unsigned C_MAX_W = 64;

  // Sequencer states.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SHIFT   = 3'd1,
    CAPTURE = 3'd2,
    FLUSH   = 3'd3,
    DONE    = 3'd4
  } state_e;

  // One Galois step over the low 'width' bits of 'val'.
  //   LFSR mode : right shift, feedback when the outgoing bit 0 is set.
  //   MISR mode : left shift, feedback when the outgoing MSB is set, then the
  //               serial input is folded into bit 0.
  function automatic logic [C_MAX_W-1:0] galois_step(
    input logic [C_MAX_W-1:0] val,
    input logic [C_MAX_W-1:0] poly,
    input int unsigned        width,
    input logic               misr_mode,
    input logic               ser_in
  );
    logic [C_MAX_W-1:0] mask;
    logic [C_MAX_W-1:0] one;
    logic [C_MAX_W-1:0] res;
    logic               msb;
    one  = C_MAX_W'(1);
    mask = {C_MAX_W{1'b1}} >> (C_MAX_W - width);
    msb  = |(val & (one << (width - 1)));
    if (misr_mode) begin
      res = ((val << 1) & mask) ^ (msb ? poly : '0) ^ (ser_in ? one : '0);
    end else begin
      res = (val >> 1) ^ (val[0] ? poly : '0);
    end
    return res & mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/s27_sig_reg.sv
`default_nettype none
// ============================================================================
// Module      : s27_sig_reg
// Description : SIG_W-bit Galois register with load, clear, step enable and
//               serial input; MISR_MODE selects MISR compaction versus LFSR
//               pattern generation. d_o exposes the next value so that the
//               caller can register outputs derived from it.
// Revision    : 1.0 - initial release
// ============================================================================
module s27_sig_reg
  import s27_scan_pkg::*;
#(
  parameter int unsigned       SIG_W     = C_SIG_W,
  parameter logic [SIG_W-1:0]  POLY      = SIG_W'(C_POLY),
  parameter logic [SIG_W-1:0]  RST_VAL   = '0,
  parameter bit                MISR_MODE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic [SIG_W-1:0] load_val_i,
  input  logic             clr_i,
  input  logic             step_i,
  input  logic             ser_i,
  output logic [SIG_W-1:0] q_o,
  output logic [SIG_W-1:0] d_o
);

  logic [SIG_W-1:0]   val_q;
  logic [SIG_W-1:0]   val_d;
  logic [C_MAX_W-1:0] w_cur_ext;
  logic [C_MAX_W-1:0] w_poly_ext;
  logic [C_MAX_W-1:0] w_step_ext;
  logic               unused_step_hi;

  // Widen the current value and polynomial, then take one Galois step.
  always_comb begin
    w_cur_ext                = '0;
    w_cur_ext[SIG_W-1:0]     = val_q;
    w_poly_ext               = '0;
    w_poly_ext[SIG_W-1:0]    = POLY;
    w_step_ext               = galois_step(w_cur_ext, w_poly_ext, SIG_W, MISR_MODE, ser_i);
  end

  assign unused_step_hi = ^w_step_ext[C_MAX_W-1:SIG_W];

  // Next value: load beats clear beats step; otherwise hold.
  always_comb begin
    val_d = val_q;
    if (load_i) begin
      val_d = load_val_i;
    end else if (clr_i) begin
      val_d = '0;
    end else if (step_i) begin
      val_d = w_step_ext[SIG_W-1:0];
    end
  end

  // Register with asynchronous reset to the mode-specific start value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      val_q <= RST_VAL;
    end else begin
      val_q <= val_d;
    end
  end

  assign q_o = val_q;
  assign d_o = val_d;

endmodule
`default_nettype wire

// File: rtl/s27_scan_seq.sv
`default_nettype none
// ============================================================================
// Module      : s27_scan_seq
// Description : Scan/BIST sequencer for the s27 core. Per pattern it shifts an
//               LFSR stream into the scan chain, applies one capture cycle
//               with LFSR-driven primary inputs, and compacts scan-out and
//               G17 into a MISR whose value is published as the signature.
// Revision    : 1.0 - initial release
// ============================================================================
module s27_scan_seq
  import s27_scan_pkg::*;
#(
  parameter int unsigned      CHAIN_LEN = 3,
  parameter int unsigned      NPAT_W    = 8,
  parameter int unsigned      SIG_W     = C_SIG_W,
  parameter logic [SIG_W-1:0] POLY      = SIG_W'(C_POLY)
) (
  input  logic              CK,
  input  logic              RN,
  input  logic              start,
  input  logic              abort,
  input  logic [NPAT_W-1:0] npat,
  input  logic [SIG_W-1:0]  seed,
  output logic              busy,
  output logic              done,
  output logic [SIG_W-1:0]  signature,
  output logic              SE,
  output logic              SI,
  output logic              CE,
  output logic [3:0]        PI,
  input  logic              SO,
  input  logic              G17
);

  localparam int unsigned        SCNT_W    = $clog2(CHAIN_LEN + 1);
  localparam logic [SCNT_W-1:0]  SCNT_LAST = SCNT_W'(CHAIN_LEN - 1);

  // Control state
  state_e              state_q, state_d;
  logic [SCNT_W-1:0]   scnt_q, scnt_d;
  logic [NPAT_W-1:0]   pcnt_q, pcnt_d;
  logic [NPAT_W-1:0]   npat_q, npat_d;
  logic                first_q, first_d;
  logic [NPAT_W:0]     w_pcnt_inc;

  // Register-bank controls
  logic                lfsr_load, lfsr_step;
  logic                misr_clr, misr_step, misr_ser;
  logic                sig_load;
  logic [SIG_W-1:0]    w_seed;
  logic [SIG_W-1:0]    lfsr_q, lfsr_d;
  logic [SIG_W-1:0]    misr_q, misr_d;
  logic                unused_bits;

  // Registered outputs
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                se_q, se_d;
  logic                si_q, si_d;
  logic                ce_q, ce_d;
  logic [3:0]          pi_q, pi_d;
  logic [SIG_W-1:0]    sig_q;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  assign w_seed     = (seed == '0) ? SIG_W'(1) : seed;
  assign w_pcnt_inc = {1'b0, pcnt_q} + 1'b1;

  s27_sig_reg #(
    .SIG_W     (SIG_W),
    .POLY      (POLY),
    .RST_VAL   (SIG_W'(1)),
    .MISR_MODE (1'b0)
  ) u_lfsr (
    .clk        (CK),
    .rst_n      (RN),
    .load_i     (lfsr_load),
    .load_val_i (w_seed),
    .clr_i      (1'b0),
    .step_i     (lfsr_step),
    .ser_i      (1'b0),
    .q_o        (lfsr_q),
    .d_o        (lfsr_d)
  );

  s27_sig_reg #(
    .SIG_W     (SIG_W),
    .POLY      (POLY),
    .RST_VAL   ('0),
    .MISR_MODE (1'b1)
  ) u_misr (
    .clk        (CK),
    .rst_n      (RN),
    .load_i     (1'b0),
    .load_val_i ('0),
    .clr_i      (misr_clr),
    .step_i     (misr_step),
    .ser_i      (misr_ser),
    .q_o        (misr_q),
    .d_o        (misr_d)
  );

  // Outputs are derived from next-state values; the remaining bits are unused.
  assign unused_bits = ^{lfsr_q, lfsr_d[SIG_W-1:4], misr_d};

  // Sequencer next-state logic and register-bank controls.
  always_comb begin
    state_d   = state_q;
    scnt_d    = scnt_q;
    pcnt_d    = pcnt_q;
    npat_d    = npat_q;
    first_d   = first_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    misr_clr  = 1'b0;
    misr_step = 1'b0;
    misr_ser  = 1'b0;
    sig_load  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          lfsr_load = 1'b1;
          misr_clr  = 1'b1;
          pcnt_d    = '0;
          npat_d    = npat;
          first_d   = 1'b1;
          scnt_d    = '0;
          state_d   = (npat == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        lfsr_step = 1'b1;
        // Chain content is unknown before the first load, so mask it.
        misr_step = ~first_q;
        misr_ser  = SO;
        if (scnt_q == SCNT_LAST) begin
          scnt_d  = '0;
          state_d = CAPTURE;
        end else begin
          scnt_d  = scnt_q + 1'b1;
        end
      end
      CAPTURE: begin
        misr_step = 1'b1;
        misr_ser  = G17;
        first_d   = 1'b0;
        pcnt_d    = w_pcnt_inc[NPAT_W-1:0];
        // Compare one bit wider so that npat = 2^NPAT_W-1 cannot wrap.
        state_d   = (w_pcnt_inc < {1'b0, npat_q}) ? SHIFT : FLUSH;
      end
      FLUSH: begin
        misr_step = 1'b1;
        misr_ser  = SO;
        if (scnt_q == SCNT_LAST) begin
          scnt_d  = '0;
          state_d = DONE;
        end else begin
          scnt_d  = scnt_q + 1'b1;
        end
      end
      DONE: begin
        sig_load = 1'b1;
        state_d  = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    // Abort overrides every other transition and freezes the banks.
    if (abort && (state_q != IDLE)) begin
      state_d   = IDLE;
      scnt_d    = '0;
      lfsr_step = 1'b0;
      misr_step = 1'b0;
      sig_load  = 1'b0;
    end
  end

  // Next values of the registered outputs, taken from the upcoming state.
  always_comb begin
    busy_d = (state_d == SHIFT) || (state_d == CAPTURE) || (state_d == FLUSH);
    done_d = (state_d == DONE);
    se_d   = (state_d == SHIFT) || (state_d == FLUSH);
    ce_d   = (state_d == CAPTURE);
    si_d   = (state_d == SHIFT) && lfsr_d[0];
    pi_d   = (state_d == CAPTURE) ? lfsr_d[3:0] : pi_q;
  end

  // Sequencer state registers.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q <= IDLE;
      scnt_q  <= '0;
      pcnt_q  <= '0;
      npat_q  <= '0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      pcnt_q  <= pcnt_d;
      npat_q  <= npat_d;
      first_q <= first_d;
    end
  end

  // Output registers; the signature only moves at the end of DONE.
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      se_q   <= 1'b0;
      si_q   <= 1'b0;
      ce_q   <= 1'b0;
      pi_q   <= 4'h0;
      sig_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      se_q   <= se_d;
      si_q   <= si_d;
      ce_q   <= ce_d;
      pi_q   <= pi_d;
      if (sig_load) begin
        sig_q <= misr_q;
      end
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign SE        = se_q;
  assign SI        = si_q;
  assign CE        = ce_q;
  assign PI        = pi_q;
  assign signature = sig_q;

endmodule
`default_nettype wire

// File: tb/tb_s27_scan_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_s27_scan_seq
// Description : Self-checking bench for s27_scan_seq. A cycle-indexed model
//               of a run predicts every registered output; directed runs add
//               hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_s27_scan_seq;

  localparam int P_IDLE  = 0;
  localparam int P_SHIFT = 1;
  localparam int P_CAP   = 2;
  localparam int P_FLUSH = 3;
  localparam int P_DONE  = 4;

  logic        CK, RN, start, abort, SO, G17;
  logic [7:0]  npat;
  logic [15:0] seed;
  logic        busy, done, SE, SI, CE;
  logic [15:0] signature;
  logic [3:0]  PI;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Model state
  bit          m_run;
  int          m_k;
  int          m_np;
  logic [15:0] m_lfsr, m_misr, m_sig;
  logic [3:0]  m_pi;
  int          e_ph;

  // Per-run traces
  logic        si_tr [64];
  logic [3:0]  pi_tr [64];
  logic        dn_tr [64];
  logic        bs_tr [64];
  logic [15:0] lf_tr [64];

  s27_scan_seq dut (
    .CK        (CK),
    .RN        (RN),
    .start     (start),
    .abort     (abort),
    .npat      (npat),
    .seed      (seed),
    .busy      (busy),
    .done      (done),
    .signature (signature),
    .SE        (SE),
    .SI        (SI),
    .CE        (CE),
    .PI        (PI),
    .SO        (SO),
    .G17       (G17)
  );

  initial begin
    CK = 1'b0;
    forever #5 CK = ~CK;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] lstep(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [15:0] mstep(input logic [15:0] v, input logic b);
    return {v[14:0], 1'b0} ^ (v[15] ? 16'hB400 : 16'h0000) ^ {15'b0, b};
  endfunction

  // Phase of cycle k (1-based from the start edge) of a run with np patterns.
  function automatic int phase_of(input int k, input int np);
    if (np == 0) return P_DONE;
    if (k <= np * 4) return (((k - 1) % 4) == 3) ? P_CAP : P_SHIFT;
    if (k <= np * 4 + 3) return P_FLUSH;
    return P_DONE;
  endfunction

  // Model: advance one cycle of the run at every rising edge.
  always @(posedge CK or negedge RN) begin
    if (!RN) begin
      m_run  <= 1'b0;
      m_k    <= 0;
      m_np   <= 0;
      m_lfsr <= 16'h0001;
      m_misr <= 16'h0000;
      m_sig  <= 16'h0000;
      m_pi   <= 4'h0;
    end else if (m_run) begin
      if (phase_of(m_k, m_np) == P_CAP) m_pi <= m_lfsr[3:0];
      if (abort) begin
        m_run <= 1'b0;
      end else begin
        case (phase_of(m_k, m_np))
          P_SHIFT: begin
            m_lfsr <= lstep(m_lfsr);
            if (m_k > 3) m_misr <= mstep(m_misr, SO);
          end
          P_CAP:   m_misr <= mstep(m_misr, G17);
          P_FLUSH: m_misr <= mstep(m_misr, SO);
          default: begin
            m_sig <= m_misr;
            m_run <= 1'b0;
          end
        endcase
        m_k <= m_k + 1;
      end
    end else if (start) begin
      m_run  <= 1'b1;
      m_k    <= 1;
      m_np   <= int'(npat);
      m_lfsr <= (seed == 16'h0000) ? 16'h0001 : seed;
      m_misr <= 16'h0000;
    end
  end

  // Compare every output against the model in the middle of each cycle.
  always @(negedge CK) begin
    if (chk_en && RN) begin
      e_ph = m_run ? phase_of(m_k, m_np) : P_IDLE;
      check("busy", 32'(busy), 32'(e_ph == P_SHIFT || e_ph == P_CAP || e_ph == P_FLUSH));
      check("done", 32'(done), 32'(e_ph == P_DONE));
      check("SE",   32'(SE),   32'(e_ph == P_SHIFT || e_ph == P_FLUSH));
      check("CE",   32'(CE),   32'(e_ph == P_CAP));
      check("SI",   32'(SI),   32'((e_ph == P_SHIFT) ? m_lfsr[0] : 1'b0));
      check("PI",   32'(PI),   32'((e_ph == P_CAP) ? m_lfsr[3:0] : m_pi));
      check("signature", 32'(signature), 32'(m_sig));
      check("SE_CE_excl", 32'(SE & CE), 32'd0);
    end
  end

  task automatic do_start(input logic [7:0] np, input logic [15:0] sd);
    start = 1'b1;
    npat  = np;
    seed  = sd;
    @(posedge CK); #2;
    start = 1'b0;
  endtask

  task automatic run_cycles(input int ncyc, input int so_mode, input int g_mode, output int done_at);
    done_at = 0;
    for (int i = 0; i < 64; i++) begin
      si_tr[i] = 1'b0; pi_tr[i] = 4'h0; dn_tr[i] = 1'b0; bs_tr[i] = 1'b0; lf_tr[i] = 16'h0;
    end
    for (int c = 1; c <= ncyc; c++) begin
      case (so_mode)
        1:       SO = (c <= 3) ? (c % 2 == 1) : 1'b1;
        2:       SO = (c >= 5 && c <= 7) ? (c % 2 == 1) : 1'b1;
        default: SO = 1'b1;
      endcase
      G17 = (g_mode == 1) ? (c % 3 == 0) : 1'b0;
      @(negedge CK);
      if (c < 64) begin
        si_tr[c] = SI; pi_tr[c] = PI; dn_tr[c] = done; bs_tr[c] = busy; lf_tr[c] = m_lfsr;
      end
      if (done && done_at == 0) done_at = c;
      @(posedge CK); #2;
    end
  endtask

  initial begin
    int d;
    int nb;
    logic [15:0] mA, mB, mC, mD;
    RN = 1'b0; start = 1'b0; abort = 1'b0; SO = 1'b0; G17 = 1'b0;
    npat = 8'd0; seed = 16'h0;

    // Reset state
    repeat (2) @(posedge CK);
    #2;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_SE", 32'(SE), 0);
    check("rst_CE", 32'(CE), 0);
    check("rst_PI", 32'(PI), 0);
    check("rst_sig", 32'(signature), 0);
    RN = 1'b1;
    @(posedge CK); #2;
    chk_en = 1'b1;

    // seed=1, npat=1, SO=1, G17=0
    do_start(8'd1, 16'h0001);
    run_cycles(10, 0, 0, d);
    check("t1_si1", 32'(si_tr[1]), 1);
    check("t1_si2", 32'(si_tr[2]), 0);
    check("t1_si3", 32'(si_tr[3]), 0);
    check("t1_lfsr1", 32'(lf_tr[1]), 32'h0001);
    check("t1_lfsr2", 32'(lf_tr[2]), 32'hB400);
    check("t1_lfsr3", 32'(lf_tr[3]), 32'h5A00);
    check("t1_lfsr4", 32'(lf_tr[4]), 32'h2D00);
    check("t1_pi", 32'(pi_tr[4]), 0);
    check("t1_done_at", 32'(d), 8);
    check("t1_busy7", 32'(bs_tr[7]), 1);
    check("t1_busy8", 32'(bs_tr[8]), 0);
    check("t1_sig", 32'(signature), 32'h0007);
    check("t1_model_sig", 32'(m_sig), 32'h0007);

    // Asynchronous reset in the middle of SHIFT
    do_start(8'd5, 16'h0003);
    run_cycles(1, 0, 0, d);
    check("rs_SI_before", 32'(SI), 1);
    chk_en = 1'b0;
    RN = 1'b0;
    #1;
    check("rs_busy", 32'(busy), 0);
    check("rs_SE", 32'(SE), 0);
    check("rs_SI", 32'(SI), 0);
    check("rs_CE", 32'(CE), 0);
    check("rs_done", 32'(done), 0);
    check("rs_PI", 32'(PI), 0);
    check("rs_sig", 32'(signature), 0);
    @(posedge CK); #2;
    RN = 1'b1;
    @(posedge CK); #2;
    chk_en = 1'b1;
    check("rs_idle_busy", 32'(busy), 0);

    // npat = 0
    do_start(8'd0, 16'h1234);
    run_cycles(4, 0, 0, d);
    nb = 0;
    for (int i = 1; i <= 4; i++) if (bs_tr[i]) nb++;
    check("z_done_at", 32'(d), 1);
    check("z_busy_cnt", 32'(nb), 0);
    check("z_sig", 32'(signature), 0);

    // npat = 3: first-shift masking and seed=0 equivalence
    do_start(8'd3, 16'h0000);
    run_cycles(20, 1, 1, d);
    check("A_done_at", 32'(d), 16);
    check("A_sig", 32'(signature), 32'(m_sig));
    mA = m_sig;
    do_start(8'd3, 16'h0000);
    run_cycles(20, 0, 1, d);
    check("B_sig", 32'(signature), 32'(m_sig));
    mB = m_sig;
    check("mask_first_shift", 32'(mB), 32'(mA));
    do_start(8'd3, 16'h0001);
    run_cycles(20, 0, 1, d);
    mC = m_sig;
    check("seed0_eq_seed1", 32'(mC), 32'(mA));
    do_start(8'd3, 16'h0000);
    run_cycles(20, 2, 1, d);
    check("D_sig", 32'(signature), 32'(m_sig));
    mD = m_sig;
    check("later_so_seen", 32'(mD != mA), 1);

    // Abort at CAPTURE of pattern 2 of 5
    do_start(8'd5, 16'hACE1);
    run_cycles(7, 0, 1, d);
    check("ab_CE_cap", 32'(CE), 1);
    abort = 1'b1;
    @(posedge CK); #2;
    abort = 1'b0;
    check("ab_SE", 32'(SE), 0);
    check("ab_CE", 32'(CE), 0);
    check("ab_busy", 32'(busy), 0);
    run_cycles(40, 0, 1, d);
    check("ab_no_done", 32'(d), 0);
    check("ab_sig_kept", 32'(signature), 32'(mD));

    // start held high through a whole run
    start = 1'b1; npat = 8'd1; seed = 16'h0005;
    @(posedge CK); #2;
    run_cycles(18, 0, 1, d);
    check("hold_done1", 32'(dn_tr[8]), 1);
    check("hold_idle_done", 32'(dn_tr[9]), 0);
    check("hold_idle_busy", 32'(bs_tr[9]), 0);
    check("hold_restart_busy", 32'(bs_tr[10]), 1);
    check("hold_done2", 32'(dn_tr[17]), 1);
    start = 1'b0;
    run_cycles(12, 0, 1, d);

    // Maximum pattern count must not wrap
    do_start(8'd255, 16'hBEEF);
    run_cycles(1030, 1, 1, d);
    check("max_done_at", 32'(d), 1024);
    check("max_sig", 32'(signature), 32'(m_sig));

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
